// File: rtl/wrsw_fabric_traffic_checker.sv
// Pattern generator and checker for the 16-bit pipelined-WB switch fabric.
// The source sends sequence-numbered frames; the sink checks them against the same pattern.
module wrsw_fabric_traffic_checker #(
  parameter int unsigned g_min_words  = 32,
  parameter int unsigned g_max_words  = 128,
  parameter int unsigned g_ifg_cycles = 4,
  parameter logic [15:0] g_ethertype  = 16'h88f7
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic [15:0] n_frames_i,
  output logic        src_cyc_o,
  output logic        src_stb_o,
  output logic [1:0]  src_adr_o,
  output logic [15:0] src_dat_o,
  output logic [1:0]  src_sel_o,
  output logic        src_we_o,
  input  logic        src_stall_i,
  input  logic        src_ack_i,
  input  logic        src_err_i,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [15:0] snk_dat_i,
  input  logic [1:0]  snk_sel_i,
  input  logic        snk_we_i,
  output logic        snk_stall_o,
  output logic        snk_ack_o,
  output logic        snk_err_o,
  output logic [31:0] tx_count_o,
  output logic [31:0] rx_count_o,
  output logic [15:0] err_count_o,
  output logic        done_o
);

  localparam int unsigned c_range = g_max_words - g_min_words + 1;
  // GAP always lasts at least one cycle so cyc falls between back-to-back frames.
  localparam int unsigned c_gap   = (g_ifg_cycles == 0) ? 1 : g_ifg_cycles;

  function automatic logic [10:0] frame_len(input logic [15:0] seq);
    return 11'(g_min_words + (32'(seq) % c_range));
  endfunction

  function automatic logic [15:0] pattern(input logic [15:0] seq, input logic [10:0] idx);
    case (idx)
      11'd0:   return 16'h0050;
      11'd1:   return 16'hcafe;
      11'd2:   return 16'hbabe;
      11'd3:   return 16'h0102;
      11'd4:   return 16'h0304;
      11'd5:   return 16'h0506;
      11'd6:   return g_ethertype;
      default: return seq + 16'(idx) - 16'd7;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_GAP} src_state_t;
  typedef enum logic {R_IDLE, R_RECV} rx_state_t;

  src_state_t  src_state, src_next;
  logic [10:0] widx, ack_cnt, ack_total, src_len;
  logic [15:0] tx_seq, sent;
  logic [31:0] gap_cnt;
  logic        accept, last, abort, frame_ok, gap_end, reached, busy;

  assign busy      = (src_state == S_SEND) || (src_state == S_WAIT_ACK);
  assign src_len   = frame_len(tx_seq);
  assign accept    = (src_state == S_SEND) && !src_stall_i;
  assign last      = (widx == src_len - 11'd1);
  assign ack_total = ack_cnt + 11'(src_ack_i);
  assign abort     = busy && src_err_i;
  assign frame_ok  = (src_state == S_WAIT_ACK) && !src_err_i && (ack_total == src_len);
  assign gap_end   = (src_state == S_GAP) && (gap_cnt == 32'(c_gap - 1));
  assign reached   = (n_frames_i != 16'd0) && (sent == n_frames_i);

  always_comb begin
    src_next = src_state;
    case (src_state)
      S_IDLE:     if (enable_i && !done_o) src_next = S_SEND;
      S_SEND:     if (abort) src_next = S_GAP;
                  else if (accept && last) src_next = S_WAIT_ACK;
      S_WAIT_ACK: if (abort || frame_ok) src_next = S_GAP;
      S_GAP:      if (gap_end) src_next = (!enable_i || reached) ? S_IDLE : S_SEND;
      default:    src_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      src_state  <= S_IDLE;
      widx       <= '0;
      ack_cnt    <= '0;
      gap_cnt    <= '0;
      tx_seq     <= '0;
      sent       <= '0;
      done_o     <= 1'b0;
      tx_count_o <= '0;
    end else begin
      src_state <= src_next;
      if (busy) begin
        if (accept && !last) widx <= widx + 11'd1;
        ack_cnt <= ack_total;
      end else begin
        widx    <= '0;
        ack_cnt <= '0;
      end
      gap_cnt <= (src_state == S_GAP && !gap_end) ? gap_cnt + 32'd1 : '0;
      if (clear_i) begin
        tx_seq     <= '0;
        tx_count_o <= '0;
      end else if (frame_ok) begin
        tx_seq     <= tx_seq + 16'd1;
        tx_count_o <= tx_count_o + 32'd1;
      end
      if (clear_i || !enable_i) begin
        sent   <= '0;
        done_o <= 1'b0;
      end else begin
        if (frame_ok) sent <= sent + 16'd1;
        if (gap_end && reached) done_o <= 1'b1;
      end
    end
  end

  assign src_cyc_o = busy;
  assign src_stb_o = (src_state == S_SEND);
  assign src_adr_o = 2'b00;
  assign src_dat_o = (src_state == S_SEND) ? pattern(tx_seq, widx) : '0;
  assign src_sel_o = 2'b11;
  assign src_we_o  = 1'b1;

  rx_state_t   rx_state, rx_next;
  logic [10:0] wcnt, cur_idx;
  logic [15:0] rseq, rx_exp;
  logic        flag, cur_flag, start, fall, word_valid, word_bad, end_bad;
  logic        sel_unused;

  assign sel_unused = ^snk_sel_i;
  assign start      = (rx_state == R_IDLE) && snk_cyc_i;
  assign fall       = (rx_state == R_RECV) && !snk_cyc_i;
  assign word_valid = snk_cyc_i && snk_stb_i && (snk_adr_i == 2'b00) && snk_we_i;
  assign cur_idx    = start ? '0 : wcnt;
  assign cur_flag   = start ? 1'b0 : flag;
  // Word 7 is checked against the expected sequence; later words against the received one.
  assign word_bad   = snk_dat_i != pattern((cur_idx == 11'd7) ? rx_exp : rseq, cur_idx);
  assign end_bad    = (wcnt < 11'd8) || flag || (wcnt != frame_len(rseq));

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (snk_cyc_i) rx_next = R_RECV;
      R_RECV:  if (!snk_cyc_i) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state    <= R_IDLE;
      snk_ack_o   <= 1'b0;
      wcnt        <= '0;
      flag        <= 1'b0;
      rseq        <= '0;
      rx_exp      <= '0;
      rx_count_o  <= '0;
      err_count_o <= '0;
    end else begin
      rx_state  <= rx_next;
      snk_ack_o <= snk_cyc_i && snk_stb_i && (snk_adr_i == 2'b00);
      if (word_valid) begin
        wcnt <= (cur_idx == '1) ? cur_idx : cur_idx + 11'd1;
        flag <= cur_flag | word_bad;
        if (cur_idx == 11'd7) rseq <= snk_dat_i;
      end else if (start) begin
        wcnt <= '0;
        flag <= 1'b0;
      end
      if (clear_i) begin
        rx_count_o  <= '0;
        err_count_o <= '0;
        rx_exp      <= '0;
      end else if (fall) begin
        rx_count_o <= rx_count_o + 32'd1;
        if (end_bad && err_count_o != 16'hffff) err_count_o <= err_count_o + 16'd1;
        if (wcnt >= 11'd8) rx_exp <= rseq + 16'd1;
      end
    end
  end

  assign snk_stall_o = 1'b0;
  assign snk_err_o   = 1'b0;

endmodule
